// File: rtl/gshare_predictor.sv
// Gshare conditional-branch direction predictor with a speculative global history and a checkpoint ring for in-order resolution.
// Optional performance counters are built when GSHARE_PREDICTOR_STATS_EN is defined.
module gshare_predictor #(
  parameter int WIDTH       = 2,
  parameter int GHR_BITS    = 8,
  parameter int PHT_ENTRIES = 256,
  parameter int CKPT_DEPTH  = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          lookup_valid_in,
  input  logic [63:0]                   lookup_pc_in,
  input  logic [WIDTH-1:0]              lookup_branch_mask_in,
  output logic                          lookup_ready_out,
  output logic                          pred_valid_out,
  output logic [WIDTH-1:0]              pred_taken_out,
  output logic [$clog2(CKPT_DEPTH)-1:0] pred_tag_out,
  input  logic                          resolve_valid_in,
  input  logic [$clog2(CKPT_DEPTH)-1:0] resolve_tag_in,
  input  logic                          resolve_taken_in,
  input  logic                          resolve_mispredict_in,
  output logic                          resolve_err_out,
  output logic [31:0]                   stat_lookups_out,
  output logic [31:0]                   stat_mispredicts_out
);
  localparam int IDX_W = $clog2(PHT_ENTRIES);
  localparam int TAG_W = $clog2(CKPT_DEPTH);
  localparam int CNT_W = TAG_W + 1;

  // Handshake: a lookup transfers on a cycle where lookup_valid_in and lookup_ready_out are both high;
  // a resolve is taken whenever resolve_valid_in is high and is either accepted or rejected that cycle.

  logic [1:0]          pht      [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [GHR_BITS-1:0] ckpt_ghr [CKPT_DEPTH];
  logic [IDX_W-1:0]    ckpt_idx [CKPT_DEPTH];
  logic [TAG_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;

  logic [IDX_W-1:0]    lane_idx  [WIDTH];
  logic [GHR_BITS-1:0] lane_ghr  [WIDTH];
  logic [TAG_W-1:0]    lane_slot [WIDTH];
  logic [WIDTH-1:0]    lane_alloc, lane_taken;
  logic [GHR_BITS-1:0] ghr_after;
  logic [CNT_W-1:0]    n_alloc;
  logic [GHR_BITS-1:0] head_ghr;
  logic [IDX_W-1:0]    head_idx;
  logic                lookup_fire, resolve_fire, mispredict_fire;
  logic                unused_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign head_ghr         = ckpt_ghr[head];
  assign head_idx         = ckpt_idx[head];
  assign lookup_ready_out = !rst_in && (count <= CNT_W'(CKPT_DEPTH - WIDTH))
                            && !(resolve_valid_in && resolve_mispredict_in);
  assign lookup_fire      = lookup_valid_in && lookup_ready_out;
  assign resolve_fire     = resolve_valid_in && (count != '0) && (resolve_tag_in == head);
  assign mispredict_fire  = resolve_fire && resolve_mispredict_in;
  assign unused_bits      = ^{lookup_pc_in[63:2+IDX_W], lookup_pc_in[1:0], head_ghr[GHR_BITS-1]};

  // Lane walk: every lane indexes with the GHR sampled at lookup, while the running history
  // advances per surviving branch so each checkpoint records the history before its own shift.
  always_comb begin
    logic [GHR_BITS-1:0] g;
    logic [CNT_W-1:0]    off;
    logic                stop;
    g          = ghr;
    off        = '0;
    stop       = 1'b0;
    lane_alloc = '0;
    lane_taken = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_idx[i]  = (lookup_pc_in[2 +: IDX_W] + IDX_W'(i)) ^ IDX_W'(ghr);
      lane_ghr[i]  = g;
      lane_slot[i] = tail + off[TAG_W-1:0];
      if (lookup_branch_mask_in[i] && !stop) begin
        lane_alloc[i] = 1'b1;
        lane_taken[i] = pht[lane_idx[i]][1];
        g             = {g[GHR_BITS-2:0], lane_taken[i]};
        off           = off + CNT_W'(1);
        stop          = lane_taken[i];
      end
    end
    ghr_after = g;
    n_alloc   = off;
  end

  always_ff @(posedge clk_in) begin
    if (lookup_fire && !rst_in) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (lane_alloc[i]) begin
          ckpt_ghr[lane_slot[i]] <= lane_ghr[i];
          ckpt_idx[lane_slot[i]] <= lane_idx[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ghr             <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      pred_valid_out  <= 1'b0;
      pred_taken_out  <= '0;
      pred_tag_out    <= '0;
      resolve_err_out <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else begin
      pred_valid_out  <= lookup_fire;
      resolve_err_out <= resolve_valid_in && !resolve_fire;
      if (lookup_fire) begin
        pred_taken_out <= lane_taken;
        pred_tag_out   <= tail;
        tail           <= tail + n_alloc[TAG_W-1:0];
      end else begin
        pred_taken_out <= '0;
      end
      if (resolve_fire) pht[head_idx] <= sat_update(pht[head_idx], resolve_taken_in);
      // A mispredict cannot coincide with an accepted lookup, so tail is stable when head jumps to it.
      if (mispredict_fire) begin
        ghr   <= {head_ghr[GHR_BITS-2:0], resolve_taken_in};
        head  <= tail;
        count <= '0;
      end else begin
        if (lookup_fire)  ghr  <= ghr_after;
        if (resolve_fire) head <= head + TAG_W'(1);
        count <= count + (lookup_fire ? n_alloc : '0) - (resolve_fire ? CNT_W'(1) : '0);
      end
    end
  end

`ifdef GSHARE_PREDICTOR_STATS_EN
  logic [31:0] stat_lookups_q, stat_mispredicts_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (lookup_fire && stat_lookups_q != '1)         stat_lookups_q     <= stat_lookups_q + 32'd1;
      if (mispredict_fire && stat_mispredicts_q != '1) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_lookups_out     = stat_lookups_q;
  assign stat_mispredicts_out = stat_mispredicts_q;
`else
  assign stat_lookups_out     = '0;
  assign stat_mispredicts_out = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the predictor.
module tb_gshare_predictor;
  localparam int WIDTH       = 2;
  localparam int GHR_BITS    = 4;
  localparam int PHT_ENTRIES = 16;
  localparam int CKPT_DEPTH  = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        lookup_valid_in = 1'b0;
  logic [63:0] lookup_pc_in = '0;
  logic [1:0]  lookup_branch_mask_in = '0;
  logic        lookup_ready_out;
  logic        pred_valid_out;
  logic [1:0]  pred_taken_out;
  logic [1:0]  pred_tag_out;
  logic        resolve_valid_in = 1'b0;
  logic [1:0]  resolve_tag_in = '0;
  logic        resolve_taken_in = 1'b0;
  logic        resolve_mispredict_in = 1'b0;
  logic        resolve_err_out;
  logic [31:0] stat_lookups_out, stat_mispredicts_out;

  gshare_predictor #(
    .WIDTH(WIDTH), .GHR_BITS(GHR_BITS), .PHT_ENTRIES(PHT_ENTRIES), .CKPT_DEPTH(CKPT_DEPTH)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .lookup_valid_in(lookup_valid_in), .lookup_pc_in(lookup_pc_in),
    .lookup_branch_mask_in(lookup_branch_mask_in), .lookup_ready_out(lookup_ready_out),
    .pred_valid_out(pred_valid_out), .pred_taken_out(pred_taken_out), .pred_tag_out(pred_tag_out),
    .resolve_valid_in(resolve_valid_in), .resolve_tag_in(resolve_tag_in),
    .resolve_taken_in(resolve_taken_in), .resolve_mispredict_in(resolve_mispredict_in),
    .resolve_err_out(resolve_err_out),
    .stat_lookups_out(stat_lookups_out), .stat_mispredicts_out(stat_mispredicts_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  // Reference model
  typedef struct { int ghr; int idx; int tag; } ck_t;
  int          m_pht [PHT_ENTRIES];
  int          m_ghr;
  ck_t         m_q[$];
  int          m_next_tag;
  longint      m_sl, m_sm;

  // Scoreboard: {valid, taken[1:0], tag[1:0]} expected after each step
  logic [4:0]  exp_q[$];
  logic        exp_ready, exp_err, obs_ready;
  logic [31:0] exp_sl, exp_sm;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic model_reset();
    for (int i = 0; i < PHT_ENTRIES; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_q.delete();
    m_next_tag = 0;
    m_sl = 0;
    m_sm = 0;
  endtask

  // Driver: applies one cycle of inputs, advances the model, leaves outputs settled after the edge.
  task automatic step(input bit r, input bit lv, input logic [63:0] pc, input logic [1:0] mask,
                      input bit rv, input logic [1:0] rtag, input bit rt, input bit rm);
    bit acc, res_ok, stop, t;
    int g, idx;
    logic [1:0] tk, tag0;
    ck_t e;
    @(negedge clk_in);
    rst_in = r; lookup_valid_in = lv; lookup_pc_in = pc; lookup_branch_mask_in = mask;
    resolve_valid_in = rv; resolve_tag_in = rtag; resolve_taken_in = rt; resolve_mispredict_in = rm;
    #1;
    obs_ready = lookup_ready_out;
    exp_ready = !r && (m_q.size() <= CKPT_DEPTH - WIDTH) && !(rv && rm);
    acc       = lv && exp_ready;
    res_ok    = !r && rv && (m_q.size() > 0) && (m_q[0].tag == int'(rtag));
    exp_err   = !r && rv && !res_ok;
    tk        = '0;
    tag0      = 2'(m_next_tag);
    if (r) begin
      model_reset();
      tag0 = '0;
    end else begin
      if (acc) begin
        g = m_ghr; stop = 0;
        for (int i = 0; i < WIDTH; i++) begin
          idx = int'(((pc + 64'(4 * i)) >> 2) % 64'(PHT_ENTRIES)) ^ m_ghr;
          if (mask[i] && !stop) begin
            t = (m_pht[idx] >= 2);
            tk[i] = t;
            m_q.push_back('{ghr: g, idx: idx, tag: m_next_tag});
            m_next_tag = (m_next_tag + 1) % CKPT_DEPTH;
            g = ((g * 2) + int'(t)) % (1 << GHR_BITS);
            if (t) stop = 1;
          end
        end
        m_ghr = g;
        if (m_sl < 64'hFFFFFFFF) m_sl++;
      end
      if (res_ok) begin
        e = m_q.pop_front();
        if (rt) m_pht[e.idx] = (m_pht[e.idx] == 3) ? 3 : m_pht[e.idx] + 1;
        else    m_pht[e.idx] = (m_pht[e.idx] == 0) ? 0 : m_pht[e.idx] - 1;
        if (rm) begin
          m_ghr = ((e.ghr * 2) + int'(rt)) % (1 << GHR_BITS);
          m_q.delete();
          if (m_sm < 64'hFFFFFFFF) m_sm++;
        end
      end
    end
`ifdef GSHARE_PREDICTOR_STATS_EN
    exp_sl = 32'(m_sl); exp_sm = 32'(m_sm);
`else
    exp_sl = '0; exp_sm = '0;
`endif
    exp_q.push_back({acc, tk, tag0});
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 64'h1000, 2'b11, 1, 2'd0, 1, 1);
    n_vec++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", obs_ready); end
    step(1, 0, '0, '0, 0, '0, 0, 0);
    n_vec++; if (pred_valid_out !== 1'b0 || pred_taken_out !== 2'b00 || pred_tag_out !== 2'd0) begin
      n_err++; $display("FAIL reset_pred: got v=%b t=%b tag=%0d want 0/00/0", pred_valid_out, pred_taken_out, pred_tag_out);
    end
    n_vec++; if (resolve_err_out !== 1'b0 || stat_lookups_out !== 32'd0 || stat_mispredicts_out !== 32'd0) begin
      n_err++; $display("FAIL reset_misc: got err=%b sl=%0d sm=%0d want 0", resolve_err_out, stat_lookups_out, stat_mispredicts_out);
    end
  endtask

  task automatic test_basic();
    step(1, 0, '0, '0, 0, '0, 0, 0);
    step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
    n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", obs_ready); end
    n_vec++; if (pred_valid_out !== 1'b1 || pred_taken_out !== 2'b00 || pred_tag_out !== 2'd0) begin
      n_err++; $display("FAIL basic_pred: got v=%b t=%b tag=%0d want 1/00/0", pred_valid_out, pred_taken_out, pred_tag_out);
    end
    idle();
    n_vec++; if (pred_valid_out !== 1'b0) begin n_err++; $display("FAIL basic_pulse: got %b want 0", pred_valid_out); end
    step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
    n_vec++; if (pred_tag_out !== 2'd1 || pred_taken_out !== 2'b00) begin
      n_err++; $display("FAIL basic_second: got tag=%0d t=%b want 1/00", pred_tag_out, pred_taken_out);
    end
  endtask

  task automatic test_saturate();
    step(1, 0, '0, '0, 0, '0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
      n_vec++; if (pred_valid_out !== 1'b1 || pred_taken_out !== 2'b00 || pred_tag_out !== 2'(k)) begin
        n_err++; $display("FAIL sat_lookup%0d: got v=%b t=%b tag=%0d want 1/00/%0d", k, pred_valid_out, pred_taken_out, pred_tag_out, k);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, '0, 1, 2'(k), 1, 0);
      n_vec++; if (resolve_err_out !== 1'b0) begin n_err++; $display("FAIL sat_resolve%0d: got err=%b want 0", k, resolve_err_out); end
    end
    step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
    n_vec++; if (pred_taken_out !== 2'b01 || pred_tag_out !== 2'd3) begin
      n_err++; $display("FAIL sat_taken: got t=%b tag=%0d want 01/3", pred_taken_out, pred_tag_out);
    end
  endtask

  task automatic test_full();
    step(1, 0, '0, '0, 0, '0, 0, 0);
    step(0, 1, 64'h1000, 2'b11, 0, '0, 0, 0);
    n_vec++; if (pred_taken_out !== 2'b00 || pred_tag_out !== 2'd0) begin
      n_err++; $display("FAIL full_first: got t=%b tag=%0d want 00/0", pred_taken_out, pred_tag_out);
    end
    step(0, 1, 64'h1000, 2'b11, 0, '0, 0, 0);
    n_vec++; if (pred_tag_out !== 2'd2) begin n_err++; $display("FAIL full_second_tag: got %0d want 2", pred_tag_out); end
    step(0, 1, 64'h1000, 2'b11, 0, '0, 0, 0);
    n_vec++; if (obs_ready !== 1'b0 || pred_valid_out !== 1'b0) begin
      n_err++; $display("FAIL full_stall: got ready=%b v=%b want 0/0", obs_ready, pred_valid_out);
    end
    step(0, 0, '0, '0, 1, 2'd0, 0, 0);
    step(0, 1, 64'h1000, 2'b11, 0, '0, 0, 0);
    n_vec++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL full_after_tag0: got ready=%b want 0", obs_ready); end
    step(0, 0, '0, '0, 1, 2'd1, 0, 0);
    step(0, 1, 64'h1000, 2'b11, 0, '0, 0, 0);
    n_vec++; if (obs_ready !== 1'b1 || pred_valid_out !== 1'b1) begin
      n_err++; $display("FAIL full_after_tag1: got ready=%b v=%b want 1/1", obs_ready, pred_valid_out);
    end
  endtask

  task automatic test_mispredict();
    logic [3:0] outcomes;
    outcomes = 4'b1101;
    step(1, 0, '0, '0, 0, '0, 0, 0);
    // History walks 0000 -> 0001 -> 0010 -> 0101 through mispredict repairs.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
      step(0, 0, '0, '0, 1, 2'(k), outcomes[k], 1);
    end
    step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
    step(0, 1, 64'h1000, 2'b01, 1, 2'd3, 1, 1);
    n_vec++; if (obs_ready !== 1'b0 || pred_valid_out !== 1'b0) begin
      n_err++; $display("FAIL mp_lookup_blocked: got ready=%b v=%b want 0/0", obs_ready, pred_valid_out);
    end
    step(0, 0, '0, '0, 1, 2'd3, 0, 0);
    n_vec++; if (resolve_err_out !== 1'b1) begin n_err++; $display("FAIL mp_ring_empty: got err=%b want 1", resolve_err_out); end
    // GHR 1011 xor base index 1011 lands on index 0, trained to 10.
    step(0, 1, 64'h2C, 2'b01, 0, '0, 0, 0);
    n_vec++; if (pred_taken_out !== 2'b01 || pred_tag_out !== 2'd0) begin
      n_err++; $display("FAIL mp_ghr_repair: got t=%b tag=%0d want 01/0", pred_taken_out, pred_tag_out);
    end
  endtask

  task automatic test_bad_tag();
    step(1, 0, '0, '0, 0, '0, 0, 0);
    step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
    step(0, 0, '0, '0, 1, 2'd2, 1, 0);
    n_vec++; if (resolve_err_out !== 1'b1) begin n_err++; $display("FAIL bad_tag_err: got %b want 1", resolve_err_out); end
    step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
    n_vec++; if (resolve_err_out !== 1'b0) begin n_err++; $display("FAIL bad_tag_pulse: got %b want 0", resolve_err_out); end
    n_vec++; if (pred_taken_out !== 2'b00 || pred_tag_out !== 2'd1) begin
      n_err++; $display("FAIL bad_tag_state: got t=%b tag=%0d want 00/1", pred_taken_out, pred_tag_out);
    end
    step(0, 0, '0, '0, 1, 2'd0, 1, 0);
    n_vec++; if (resolve_err_out !== 1'b0) begin n_err++; $display("FAIL bad_tag_head: got %b want 0", resolve_err_out); end
  endtask

  task automatic test_stats();
    logic [31:0] want_l, want_m;
`ifdef GSHARE_PREDICTOR_STATS_EN
    want_l = 32'd3; want_m = 32'd1;
`else
    want_l = 32'd0; want_m = 32'd0;
`endif
    step(1, 0, '0, '0, 0, '0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 64'h1000, 2'b01, 0, '0, 0, 0);
    step(0, 0, '0, '0, 1, 2'd0, 1, 1);
    idle();
    n_vec++; if (stat_lookups_out !== want_l || stat_mispredicts_out !== want_m) begin
      n_err++; $display("FAIL stats: got %0d/%0d want %0d/%0d", stat_lookups_out, stat_mispredicts_out, want_l, want_m);
    end
  endtask

  task automatic test_random();
    logic [4:0]  e;
    logic [63:0] pc;
    logic [1:0]  rtag;
    bit          r;
    step(1, 0, '0, '0, 0, '0, 0, 0);
    exp_q.delete();
    for (int k = 0; k < 800; k++) begin
      pc   = {$urandom, $urandom} & ~64'h3;
      rtag = 2'($urandom_range(0, 3));
      if (m_q.size() > 0 && $urandom_range(0, 7) != 0) rtag = 2'(m_q[0].tag);
      r = ($urandom_range(0, 59) == 0);
      step(r, $urandom_range(0, 9) < 7, pc, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, rtag, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      e = exp_q.pop_front();
      n_vec++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", k, obs_ready, exp_ready); end
      n_vec++; if (pred_valid_out !== e[4]) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", k, pred_valid_out, e[4]); end
      if (e[4]) begin
        n_vec++; if (pred_taken_out !== e[3:2] || pred_tag_out !== e[1:0]) begin
          n_err++; $display("FAIL rnd_pred@%0d: got t=%b tag=%0d want t=%b tag=%0d", k, pred_taken_out, pred_tag_out, e[3:2], e[1:0]);
        end
      end
      n_vec++; if (resolve_err_out !== exp_err) begin n_err++; $display("FAIL rnd_err@%0d: got %b want %b", k, resolve_err_out, exp_err); end
      n_vec++; if (stat_lookups_out !== exp_sl || stat_mispredicts_out !== exp_sm) begin
        n_err++; $display("FAIL rnd_stats@%0d: got %0d/%0d want %0d/%0d", k, stat_lookups_out, stat_mispredicts_out, exp_sl, exp_sm);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_saturate();
    test_full();
    test_mispredict();
    test_bad_tag();
    test_stats();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
